sample_pkt_framer: RTL and testbench

Packet framer for the compute-engine side of an RFNoC block. It takes an unframed 32-bit sample stream from a user core with no tlast and emits AXI-stream packets of a programmable length, with tlast on the final beat. This is the framing that `axi_wrapper` in SIMPLE_MODE requires on its `s_axis_data` input. The framer is the producing counterpart of the null-processing cores, which consume framed packets. Configuration comes from the NoC-shell settings bus.

---
 rtl/sample_pkt_framer.sv | 179 +++++++++++++++++
 tb/tb_sample_pkt_framer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_pkt_framer.sv
// Frames an unframed 32-bit sample stream into fixed-length AXI-stream packets with tlast.
// Optional FRAMER_PAD_EN: flush or disable mid-packet completes the packet with zero samples.
module sample_pkt_framer #(
    parameter int SR_PKT_LEN = 129,
    parameter int SR_CTRL    = 130,
    parameter int LEN_W      = 16
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] pkt_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
`ifdef FRAMER_PAD_EN
        , ST_PAD = 2'd2
`endif
    } state_t;

    localparam logic [7:0]       ADDR_LEN  = 8'(SR_PKT_LEN);
    localparam logic [7:0]       ADDR_CTRL = 8'(SR_CTRL);
    localparam logic [LEN_W-1:0] LEN_RST   = LEN_W'(256);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    state_t             state, state_d;
    logic [LEN_W-1:0]   pkt_len;
    logic [LEN_W-1:0]   len_active;
    logic [LEN_W-1:0]   beat_cnt;
    logic               enable;
`ifdef FRAMER_PAD_EN
    logic               flush_p;
`endif

    logic [31:0]        tdata_p1;
    logic               tlast_p1;
    logic               vld_p1;

    logic               hs, last_hs, can_load, mid_pkt, s_hs;
    logic               ld_en, ld_last;
    logic [31:0]        ld_data;
    logic [LEN_W-1:0]   ld_idx, len_eff;
    logic               unused_bits;

    assign unused_bits = ^set_data[31:LEN_W];

    // Settings bus: registered, so every write lands the cycle after set_stb
    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            pkt_len <= LEN_RST;
            enable  <= 1'b0;
`ifdef FRAMER_PAD_EN
            flush_p <= 1'b0;
`endif
        end else begin
`ifdef FRAMER_PAD_EN
            flush_p <= 1'b0;
`endif
            if (set_stb && set_addr == ADDR_LEN) begin
                pkt_len <= (set_data[LEN_W-1:0] == '0) ? LEN_ONE : set_data[LEN_W-1:0];
            end
            if (set_stb && set_addr == ADDR_CTRL) begin
                enable  <= set_data[0];
`ifdef FRAMER_PAD_EN
                flush_p <= set_data[1];
`endif
            end
        end
    end

    assign hs       = vld_p1 & m_axis_tready;
    assign last_hs  = hs & tlast_p1;
    assign can_load = ~vld_p1 | m_axis_tready;
    // A packet is open once a beat has left or is waiting, until its tlast beat is loaded
    assign mid_pkt  = ((beat_cnt != '0) | vld_p1) & ~(vld_p1 & tlast_p1);

    assign s_axis_tready = (state == ST_RUN) & can_load;
    assign s_hs          = s_axis_tready & s_axis_tvalid;

    // Position of the beat being loaded; a tlast handshake this cycle starts a new packet
    always_comb begin
        ld_idx  = beat_cnt;
        len_eff = len_active;
        if (last_hs) begin
            ld_idx  = '0;
            len_eff = pkt_len;
        end else if (hs) begin
            ld_idx  = beat_cnt + LEN_ONE;
        end
        ld_last = (ld_idx == len_eff - LEN_ONE);
    end

    always_comb begin
        state_d = state;
        ld_en   = 1'b0;
        ld_data = s_axis_tdata;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
`ifdef FRAMER_PAD_EN
                end else if (mid_pkt) begin
                    state_d = ST_PAD;
`endif
                end
            end
            ST_RUN: begin
                ld_en = s_hs;
                if (last_hs) begin
                    state_d = enable ? ST_RUN : ST_IDLE;
`ifdef FRAMER_PAD_EN
                end else if (mid_pkt && (flush_p || !enable)) begin
                    state_d = ST_PAD;
`endif
                end else if (!enable && !mid_pkt && !s_hs) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef FRAMER_PAD_EN
            ST_PAD: begin
                ld_en   = can_load & ~(vld_p1 & tlast_p1);
                ld_data = '0;
                if (last_hs) begin
                    state_d = enable ? ST_RUN : ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output stage p1: single register, held while the consumer stalls
    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            pkt_count  <= '0;
            len_active <= LEN_RST;
            vld_p1     <= 1'b0;
            tlast_p1   <= 1'b0;
            tdata_p1   <= '0;
        end else begin
            state <= state_d;
            if (ld_en) begin
                vld_p1   <= 1'b1;
                tdata_p1 <= ld_data;
                tlast_p1 <= ld_last;
            end else if (hs) begin
                vld_p1 <= 1'b0;
            end
            if (hs) begin
                beat_cnt <= tlast_p1 ? '0 : beat_cnt + LEN_ONE;
            end
            if (last_hs) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (last_hs || (state == ST_IDLE && !mid_pkt)) begin
                len_active <= pkt_len;
            end
        end
    end

    assign m_axis_tdata  = tdata_p1;
    assign m_axis_tlast  = tlast_p1;
    assign m_axis_tvalid = vld_p1;
    assign busy          = (beat_cnt != '0) | (vld_p1 & ~tlast_p1);

endmodule

// File: tb/tb_sample_pkt_framer.sv
// Scoreboard bench for sample_pkt_framer: packet-level reference model feeds an expected-beat queue.
module tb_sample_pkt_framer;

    logic        ce_clk = 1'b0;
    logic        ce_rst;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] pkt_count;
    logic        busy;

    sample_pkt_framer #(.SR_PKT_LEN(129), .SR_CTRL(130), .LEN_W(16)) dut (
        .ce_clk(ce_clk), .ce_rst(ce_rst),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .pkt_count(pkt_count), .busy(busy)
    );

    always #5 ce_clk = ~ce_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bp_mode = 0;
    logic [32:0] exp_q[$];
    int model_len = 256;
    int model_pos = 0;
    int model_cur = 256;
    int model_pkts = 0;

    always @(posedge ce_clk) cyc++;

    // Consumer ready: always high, or a fair coin each cycle
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge ce_clk);
            #1;
            m_axis_tready = (bp_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Packet model: each packet's length is the PKT_LEN in force when its first sample is taken
    function automatic void model_push(input logic [31:0] d);
        if (model_pos == 0) model_cur = model_len;
        model_pos++;
        if (model_pos == model_cur) begin
            exp_q.push_back({1'b1, d});
            model_pos = 0;
            model_pkts++;
        end else begin
            exp_q.push_back({1'b0, d});
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge ce_clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_addr = a;
        set_data = d;
        set_stb  = 1'b1;
        @(posedge ce_clk);
        #1;
        set_stb = 1'b0;
        if (a == 8'd129) model_len = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
    endtask

    task automatic send(input logic [31:0] d);
        int guard = 0;
        logic acc = 1'b0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        do begin
            @(negedge ce_clk);
            acc = s_axis_tready;
            @(posedge ce_clk);
            guard++;
        end while (!acc && guard < 1000);
        #1;
        s_axis_tvalid = 1'b0;
        if (acc) begin
            model_push(d);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", d);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge ce_clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
        end
        idle(2);
    endtask

    // Monitor: pops on each output handshake and checks stall stability
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;
    logic [32:0] mon_e;
    always @(negedge ce_clk) begin
        if (ce_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!m_axis_tvalid || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l) begin
                    errors++;
                    $display("FAIL stall_hold actual=v%0b/%0h/l%0b required=v1/%0h/l%0b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_d, prev_l);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h/l%0b required=no_beat", m_axis_tdata, m_axis_tlast);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (m_axis_tdata !== mon_e[31:0] || m_axis_tlast !== mon_e[32]) begin
                        errors++;
                        $display("FAIL beat actual=%0h/l%0b required=%0h/l%0b",
                                 m_axis_tdata, m_axis_tlast, mon_e[31:0], mon_e[32]);
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d     = m_axis_tdata;
            prev_l     = m_axis_tlast;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int plen;
        ce_rst = 1'b1;
        set_stb = 1'b0;
        set_addr = '0;
        set_data = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        repeat (3) @(posedge ce_clk);
        #1;
        check("rst_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_tlast", 32'(m_axis_tlast), 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tready", 32'(s_axis_tready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pkt_count", pkt_count, 0);
        ce_rst = 1'b0;
        idle(2);
        check("idle_tready", 32'(s_axis_tready), 0);

        // Length 4, 12 back-to-back samples
        wr(8'd129, 32'd4);
        wr(8'd130, 32'd1);
        idle(3);
        t0 = cyc;
        for (int i = 1; i <= 12; i++) send(32'(i));
        check("throughput_cycles", 32'(cyc - t0), 12);
        drain();
        check("pkt_count_len4", pkt_count, 3);
        check("busy_after_len4", 32'(busy), 0);

        // Length 0 stored as 1
        wr(8'd130, 32'd0);
        idle(2);
        wr(8'd129, 32'd0);
        wr(8'd130, 32'd1);
        idle(3);
        for (int i = 0; i < 5; i++) send($urandom);
        drain();
        check("pkt_count_len1", pkt_count, 32'(model_pkts));

        // Length change mid-packet takes effect at the next packet
        wr(8'd130, 32'd0);
        idle(2);
        wr(8'd129, 32'd8);
        wr(8'd130, 32'd1);
        idle(3);
        for (int i = 0; i < 3; i++) send(32'h100 + 32'(i));
        wr(8'd129, 32'd2);
        for (int i = 3; i < 12; i++) send(32'h100 + 32'(i));
        drain();
        check("pkt_count_lenchg", pkt_count, 32'(model_pkts));

        // Flush of a partial packet
        wr(8'd130, 32'd0);
        idle(2);
        wr(8'd129, 32'd6);
        wr(8'd130, 32'd1);
        idle(3);
        send(32'hA);
        send(32'hB);
        idle(3);
        check("busy_partial", 32'(busy), 1);
        wr(8'd130, 32'd3);
`ifdef FRAMER_PAD_EN
        for (int i = 0; i < 4; i++) model_push(32'd0);
`else
        idle(10);
        check("flush_ignored_count", pkt_count, 32'(model_pkts));
        for (int i = 0; i < 4; i++) send(32'hC + 32'(i));
`endif
        drain();
        check("pkt_count_flush", pkt_count, 32'(model_pkts));
        check("busy_after_flush", 32'(busy), 0);

        // Random data and gaps under 50% backpressure
        wr(8'd130, 32'd0);
        idle(2);
        plen = int'($urandom_range(1, 7));
        wr(8'd129, 32'(plen));
        wr(8'd130, 32'd1);
        idle(3);
        bp_mode = 1;
        for (int i = 0; i < plen * 30; i++) begin
            send($urandom);
            idle(int'($urandom_range(0, 2)));
        end
        drain();
        bp_mode = 0;
        idle(2);
        check("pkt_count_random", pkt_count, 32'(model_pkts));

        // Reset mid-packet, then default length of 256
        wr(8'd130, 32'd0);
        idle(2);
        wr(8'd129, 32'd8);
        wr(8'd130, 32'd1);
        idle(3);
        for (int i = 0; i < 3; i++) send(32'h200 + 32'(i));
        drain();
        check("busy_before_rst", 32'(busy), 1);
        ce_rst = 1'b1;
        @(posedge ce_clk);
        #1;
        ce_rst = 1'b0;
        exp_q.delete();
        model_len = 256;
        model_pos = 0;
        model_pkts = 0;
        check("midrst_tvalid", 32'(m_axis_tvalid), 0);
        check("midrst_pkt_count", pkt_count, 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_tready", 32'(s_axis_tready), 0);
        wr(8'd130, 32'd1);
        idle(3);
        for (int i = 0; i < 256; i++) send(32'h1000 + 32'(i));
        drain();
        check("pkt_count_len256", pkt_count, 1);
        check("busy_after_256", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
